// File: rtl/dct_add_arbiter_pkg.sv
// Shared constants, stage records and packing helper for the DCT adder arbiter.
package dct_add_arbiter_pkg;

  // Operand width is fixed by the recursive-doubling adder.
  localparam int ADD_W = 40;

  // Default requester count and matching id width.
  localparam int NREQ_DEFAULT = 4;
  localparam int ID_W_DEFAULT = 2;

  // Prefix levels needed so that the doubling span (2^levels) covers ADD_W bits.
  localparam int ADD_LVLS = 6;

  // Operand stage: one op waiting to go through the adder.
  typedef struct packed {
    logic             vld;
    logic [ADD_W-1:0] a;
    logic [ADD_W-1:0] b;
    logic             acc;
  } s1_t;

  // Result stage payload (id and valid are kept separately because of parameter widths).
  typedef struct packed {
    logic [ADD_W-1:0] sum;
    logic             carry;
    logic             acc;
  } res_t;

  // Bit offset of requester idx inside a packed NREQ*ADD_W operand bus.
  function automatic int op_lsb(input int idx);
    return idx * ADD_W;
  endfunction

endpackage

// File: rtl/dct_add_arbiter_recurse40.sv
// 40-bit recursive-doubling (parallel-prefix) adder, carry-in tied to zero.
module recurse40
  import dct_add_arbiter_pkg::*;
(
  input  logic [ADD_W-1:0] a,
  input  logic [ADD_W-1:0] b,
  output logic [ADD_W-1:0] sum,
  output logic             cout
);

  logic [ADD_W-1:0] half_sum;
  logic [ADD_W-1:0] carry_vec;

  assign half_sum = a ^ b;

  // Prefix tree: each level doubles the span of every (generate, propagate) group.
  always_comb begin : p_prefix
    logic [ADD_W-1:0] g;
    logic [ADD_W-1:0] p;
    logic [ADD_W-1:0] g_nx;
    logic [ADD_W-1:0] p_nx;
    g    = a & b;
    p    = a ^ b;
    g_nx = g;
    p_nx = p;
    for (int lvl = 0; lvl < ADD_LVLS; lvl++) begin
      g_nx = g;
      p_nx = p;
      for (int i = (1 << lvl); i < ADD_W; i++) begin
        g_nx[i] = g[i] | (p[i] & g[i - (1 << lvl)]);
        p_nx[i] = p[i] & p[i - (1 << lvl)];
      end
      g = g_nx;
      p = p_nx;
    end
    // carry_vec[i] is the carry out of bit i (group generate over bits [i:0]).
    carry_vec = g;
  end

  // Sum bit i combines the local half-sum with the carry coming out of bit i-1.
  genvar gi;
  generate
    for (gi = 0; gi < ADD_W; gi++) begin : g_sum
      if (gi == 0) begin : g_lsb
        assign sum[gi] = half_sum[gi];
      end else begin : g_upper
        assign sum[gi] = half_sum[gi] ^ carry_vec[gi-1];
      end
    end
  endgenerate

  assign cout = carry_vec[ADD_W-1];

endmodule

// File: rtl/dct_add_arbiter.sv
// Round-robin arbiter sharing one 40-bit adder among NREQ DCT accumulation requesters.
// Two-stage pipeline: operand register (s1) -> recurse40 -> result register (s2).
// Each requester owns a running 40-bit accumulator that can replace operand b.
module dct_add_arbiter
  import dct_add_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEFAULT,
  parameter int ID_W = ID_W_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*ADD_W-1:0]   req_a,
  input  logic [NREQ*ADD_W-1:0]   req_b,
  input  logic [NREQ-1:0]         req_acc,
  input  logic [NREQ-1:0]         acc_clr,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [ADD_W-1:0]        res_sum,
  output logic                    res_carry,
  output logic [ID_W-1:0]         res_id,
  output logic                    res_acc
);

  // Operand stage
  s1_t             s1_q, s1_d;
  logic [ID_W-1:0] s1_id_q, s1_id_d;

  // Result stage
  res_t            res_q, res_d;
  logic            res_valid_q, res_valid_d;
  logic [ID_W-1:0] res_id_q, res_id_d;

  // Per-requester accumulators and round-robin pointer (last granted id)
  logic [ADD_W-1:0] acc_q [NREQ];
  logic [ADD_W-1:0] acc_d [NREQ];
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;

  // Control and datapath nets
  logic             s1_load;
  logic             s2_load;
  logic [NREQ-1:0]  eligible;
  logic [NREQ-1:0]  grant;
  logic             grant_any;
  logic [ID_W-1:0]  grant_id;
  logic [ADD_W-1:0] op_a [NREQ];
  logic [ADD_W-1:0] op_b [NREQ];
  logic [ADD_W-1:0] add_sum;
  logic             add_carry;

  // s2 accepts whenever it is empty or being drained; s1 refills when empty or moving on.
  assign s2_load = s1_q.vld & (~res_valid_q | res_ready);
  assign s1_load = ~s1_q.vld | s2_load;

  // Per-requester operand selection and eligibility. A requester whose op still
  // sits in s1 is held off so its next accumulate sees the updated accumulator.
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign op_a[gi]     = req_a[op_lsb(gi) +: ADD_W];
      assign op_b[gi]     = req_acc[gi] ? acc_q[gi] : req_b[op_lsb(gi) +: ADD_W];
      assign eligible[gi] = req_valid[gi] & ~(s1_q.vld & (s1_id_q == ID_W'(gi)));
    end
  endgenerate

  // Round-robin search starting just after the last granted requester.
  always_comb begin : p_grant
    int idx;
    idx       = 0;
    grant     = '0;
    grant_any = 1'b0;
    grant_id  = '0;
    if (s1_load && !rst) begin
      for (int k = 1; k <= NREQ; k++) begin
        idx = int'(rr_ptr_q) + k;
        if (idx >= NREQ) begin
          idx = idx - NREQ;
        end
        if (!grant_any && eligible[idx]) begin
          grant[idx] = 1'b1;
          grant_any  = 1'b1;
          grant_id   = ID_W'(idx);
        end
      end
    end
  end

  // Shared adder between the operand and result stages.
  recurse40 u_add (
    .a    (s1_q.a),
    .b    (s1_q.b),
    .sum  (add_sum),
    .cout (add_carry)
  );

  // Operand stage capture and round-robin pointer update on a handshake.
  always_comb begin : p_s1_next
    s1_d     = s1_q;
    s1_id_d  = s1_id_q;
    rr_ptr_d = rr_ptr_q;
    if (s1_load) begin
      s1_d.vld = grant_any;
      if (grant_any) begin
        s1_d.a   = op_a[grant_id];
        s1_d.b   = op_b[grant_id];
        s1_d.acc = req_acc[grant_id];
        s1_id_d  = grant_id;
        rr_ptr_d = grant_id;
      end
    end
  end

  // Result stage: load from the adder, hold under backpressure, clear once drained.
  always_comb begin : p_s2_next
    res_d       = res_q;
    res_id_d    = res_id_q;
    res_valid_d = res_valid_q;
    if (s2_load) begin
      res_d.sum   = add_sum;
      res_d.carry = add_carry;
      res_d.acc   = s1_q.acc;
      res_id_d    = s1_id_q;
      res_valid_d = 1'b1;
    end else if (res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  // Accumulator write-back; a clear on the same edge overrides the write.
  always_comb begin : p_acc_next
    for (int i = 0; i < NREQ; i++) begin
      acc_d[i] = acc_q[i];
      if (acc_clr[i]) begin
        acc_d[i] = '0;
      end else if (s2_load && s1_q.acc && (s1_id_q == ID_W'(i))) begin
        acc_d[i] = add_sum;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q        <= '0;
      s1_id_q     <= '0;
      res_q       <= '0;
      res_id_q    <= '0;
      res_valid_q <= 1'b0;
      rr_ptr_q    <= ID_W'(NREQ - 1);
      for (int i = 0; i < NREQ; i++) begin
        acc_q[i] <= '0;
      end
    end else begin
      s1_q        <= s1_d;
      s1_id_q     <= s1_id_d;
      res_q       <= res_d;
      res_id_q    <= res_id_d;
      res_valid_q <= res_valid_d;
      rr_ptr_q    <= rr_ptr_d;
      for (int i = 0; i < NREQ; i++) begin
        acc_q[i] <= acc_d[i];
      end
    end
  end

  assign req_ready = grant;
  assign res_valid = res_valid_q;
  assign res_sum   = res_q.sum;
  assign res_carry = res_q.carry;
  assign res_acc   = res_q.acc;
  assign res_id    = res_id_q;

endmodule

// File: tb/tb_dct_add_arbiter.sv
// Directed bench for dct_add_arbiter: table of single ops plus hand-written
// fairness, backpressure, accumulator-clear and reset sequences.
module tb_dct_add_arbiter;

  localparam int NREQ = 4;
  localparam int ID_W = 2;
  localparam int W    = 40;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*W-1:0]   req_a;
  logic [NREQ*W-1:0]   req_b;
  logic [NREQ-1:0]     req_acc;
  logic [NREQ-1:0]     acc_clr;
  logic                res_valid;
  logic                res_ready;
  logic [W-1:0]        res_sum;
  logic                res_carry;
  logic [ID_W-1:0]     res_id;
  logic                res_acc;

  int n_pass  = 0;
  int n_total = 0;

  dct_add_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_acc   (req_acc),
    .acc_clr   (acc_clr),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_carry (res_carry),
    .res_id    (res_id),
    .res_acc   (res_acc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   id;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         acc;
    logic [W-1:0] exp_sum;
    logic         exp_carry;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated op: handshake, check latency and result, let it drain.
  task automatic do_op(input vec_t v, input logic [3:0] clr_hs, input logic [3:0] clr_wb,
                       input string tag);
    int waited;
    logic [3:0] onehot;
    onehot = 4'b0001 << v.id;
    req_valid = onehot;
    req_a[int'(v.id)*W +: W] = v.a;
    req_b[int'(v.id)*W +: W] = v.b;
    req_acc   = v.acc ? onehot : 4'b0000;
    acc_clr   = clr_hs;
    res_ready = 1'b1;
    #1;
    waited = 0;
    while (req_ready[v.id] !== 1'b1 && waited < 10) begin
      tick();
      waited++;
    end
    chk({tag, "_grant"}, {60'd0, req_ready}, {60'd0, onehot});
    tick();
    req_valid = '0;
    req_acc   = '0;
    acc_clr   = clr_wb;
    chk({tag, "_lat0"}, {63'd0, res_valid}, 64'd0);
    tick();
    acc_clr = '0;
    chk({tag, "_valid"}, {63'd0, res_valid}, 64'd1);
    chk({tag, "_sum"},   {24'd0, res_sum}, {24'd0, v.exp_sum});
    chk({tag, "_carry"}, {63'd0, res_carry}, {63'd0, v.exp_carry});
    chk({tag, "_id"},    {62'd0, res_id}, {62'd0, v.id});
    chk({tag, "_acc"},   {63'd0, res_acc}, {63'd0, v.acc});
    $display("op %s id=%0d a=%0h b=%0h acc=%0d -> sum=%0h carry=%0d", tag, v.id, v.a, v.b,
             v.acc, res_sum, res_carry);
    tick();
    chk({tag, "_drain"}, {63'd0, res_valid}, 64'd0);
  endtask

  task automatic set_all_ops();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*W +: W] = W'(100 + i);
      req_b[i*W +: W] = W'(i);
    end
  endtask

  initial begin
    vec_t v;

    vecs[0] = '{2'd0, 40'd1, 40'd2, 1'b0, 40'd3, 1'b0};
    vecs[1] = '{2'd0, 40'hFF_FFFF_FFFF, 40'd1, 1'b0, 40'd0, 1'b1};
    vecs[2] = '{2'd2, 40'h80_0000_0000, 40'h80_0000_0000, 1'b0, 40'd0, 1'b1};
    vecs[3] = '{2'd3, 40'h12_3456_789A, 40'h01_0101_0101, 1'b0, 40'h13_3557_799B, 1'b0};
    vecs[4] = '{2'd1, 40'd5, 40'hDEAD, 1'b1, 40'd5, 1'b0};
    vecs[5] = '{2'd1, 40'd5, 40'hDEAD, 1'b1, 40'd10, 1'b0};
    vecs[6] = '{2'd1, 40'd5, 40'hDEAD, 1'b1, 40'd15, 1'b0};
    vecs[7] = '{2'd2, 40'd9, 40'hBEEF, 1'b1, 40'd9, 1'b0};
    vecs[8] = '{2'd3, 40'hAA_AAAA_AAAA, 40'h55_5555_5555, 1'b0, 40'hFF_FFFF_FFFF, 1'b0};
    vecs[9] = '{2'd1, 40'hFF_FFFF_FFFF, 40'hFF_FFFF_FFFF, 1'b0, 40'hFF_FFFF_FFFE, 1'b1};

    // Reset state (requests pending while reset is held must not be granted)
    rst       = 1'b1;
    req_valid = 4'hF;
    req_a     = '0;
    req_b     = '0;
    req_acc   = '0;
    acc_clr   = '0;
    res_ready = 1'b0;
    tick();
    tick();
    chk("rst_res_valid", {63'd0, res_valid}, 64'd0);
    chk("rst_req_ready", {60'd0, req_ready}, 64'd0);
    chk("rst_res_sum",   {24'd0, res_sum}, 64'd0);
    chk("rst_res_id",    {62'd0, res_id}, 64'd0);
    $display("reset: res_valid=%0d req_ready=%b", res_valid, req_ready);
    rst = 1'b0;

    // Fairness: all valid, sink always ready
    set_all_ops();
    req_valid = 4'hF;
    res_ready = 1'b1;
    #1;
    for (int k = 0; k < 8; k++) begin
      chk("fair_grant", {60'd0, req_ready}, 64'd1 << (k % 4));
      tick();
      if (k > 0) begin
        chk("fair_valid", {63'd0, res_valid}, 64'd1);
        chk("fair_id",    {62'd0, res_id}, 64'((k - 1) % 4));
        chk("fair_sum",   {24'd0, res_sum}, 64'(100 + 2 * ((k - 1) % 4)));
      end
      $display("fair k=%0d res_valid=%0d res_id=%0d res_sum=%0d", k, res_valid, res_id, res_sum);
    end
    req_valid = '0;
    tick();
    chk("fair_last_id",    {62'd0, res_id}, 64'd3);
    chk("fair_last_valid", {63'd0, res_valid}, 64'd1);
    tick();
    chk("fair_empty", {63'd0, res_valid}, 64'd0);

    // Backpressure: sink stalled with all requesters valid
    req_valid = 4'hF;
    res_ready = 1'b0;
    #1;
    chk("bp_grant0", {60'd0, req_ready}, 64'h1);
    tick();
    chk("bp_valid0", {63'd0, res_valid}, 64'd0);
    chk("bp_grant1", {60'd0, req_ready}, 64'h2);
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("bp_hold_ready", {60'd0, req_ready}, 64'd0);
      chk("bp_hold_valid", {63'd0, res_valid}, 64'd1);
      chk("bp_hold_id",    {62'd0, res_id}, 64'd0);
      chk("bp_hold_sum",   {24'd0, res_sum}, 64'd100);
      $display("bp hold %0d: req_ready=%b res_id=%0d res_sum=%0d", k, req_ready, res_id, res_sum);
      tick();
    end
    res_ready = 1'b1;
    req_valid = '0;
    tick();
    chk("bp_drain_valid", {63'd0, res_valid}, 64'd1);
    chk("bp_drain_id",    {62'd0, res_id}, 64'd1);
    chk("bp_drain_sum",   {24'd0, res_sum}, 64'd102);
    tick();
    chk("bp_drain_empty", {63'd0, res_valid}, 64'd0);

    // Table of isolated ops
    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i], 4'b0000, 4'b0000, $sformatf("vec%0d", i));
    end

    // Clear acc[1] on its own, then accumulate 7
    acc_clr = 4'b0010;
    tick();
    acc_clr = '0;
    v = '{2'd1, 40'd7, 40'd0, 1'b1, 40'd7, 1'b0};
    do_op(v, 4'b0000, 4'b0000, "clr_then_acc");
    // Clear during the grant: the op still sees the pre-clear value (7+3)
    v = '{2'd1, 40'd3, 40'd0, 1'b1, 40'd10, 1'b0};
    do_op(v, 4'b0010, 4'b0000, "clr_at_grant");
    // Clear during the write-back: the clear wins, acc[1] ends at 0
    v = '{2'd1, 40'd1, 40'd0, 1'b1, 40'd11, 1'b0};
    do_op(v, 4'b0000, 4'b0010, "clr_at_wb");
    v = '{2'd1, 40'd2, 40'd0, 1'b1, 40'd2, 1'b0};
    do_op(v, 4'b0000, 4'b0000, "after_clr_wb");
    // acc[2] untouched by all of the above (9 + 1)
    v = '{2'd2, 40'd1, 40'd0, 1'b1, 40'd10, 1'b0};
    do_op(v, 4'b0000, 4'b0000, "acc2_kept");

    // Reset with both stages full
    set_all_ops();
    req_valid = 4'hF;
    res_ready = 1'b0;
    tick();
    tick();
    chk("pre_rst_full", {63'd0, res_valid}, 64'd1);
    rst = 1'b1;
    tick();
    chk("mid_rst_valid", {63'd0, res_valid}, 64'd0);
    chk("mid_rst_ready", {60'd0, req_ready}, 64'd0);
    chk("mid_rst_sum",   {24'd0, res_sum}, 64'd0);
    chk("mid_rst_carry", {63'd0, res_carry}, 64'd0);
    $display("mid reset: res_valid=%0d req_ready=%b", res_valid, req_ready);
    rst       = 1'b0;
    res_ready = 1'b1;
    #1;
    chk("post_rst_rr", {60'd0, req_ready}, 64'h1);
    req_valid = '0;
    v = '{2'd1, 40'd7, 40'd0, 1'b1, 40'd7, 1'b0};
    do_op(v, 4'b0000, 4'b0000, "post_rst_acc");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
